// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter: FSM state encodings, register
// word addresses and CTRL bit positions, used by the block, bridge and bench.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tcState_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_MODE_MSB   = 2;
  localparam int CTRL_IM_BIT     = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Only Mode 1 auto-reloads; every other encoding behaves as one-shot.
  function automatic logic isReloadMode(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// CTRL holds Enable/Mode/IM, PRESET is the reload value, COUNT is read-only.
// TC_o_IRQ is the latched irq flag gated by the interrupt mask.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  TC_i_Addr,
  input  logic [31:0] TC_i_WData,
  input  logic        TC_i_WEnable,
  output logic [31:0] TC_o_RData,
  output logic        TC_o_IRQ
);

  tcState_e    state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irqFlag_q, irqFlag_d;

  logic        ctrlWrite;
  logic        presetWrite;
  logic        ctrlEnable;
  logic [1:0]  ctrlMode;

  assign ctrlWrite   = TC_i_WEnable && (TC_i_Addr == ADDR_CTRL);
  assign presetWrite = TC_i_WEnable && (TC_i_Addr == ADDR_PRESET);
  assign ctrlEnable  = ctrl_q[CTRL_ENABLE_BIT];
  assign ctrlMode    = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

  // Next-state for FSM and counter; bus writes are applied last so a CTRL
  // write overrides the hardware clearing Enable and always clears the flag.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    irqFlag_d = irqFlag_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrlEnable) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrlEnable) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d   = 32'd0;
          irqFlag_d = 1'b1;
          state_d   = ST_INT;
        end
      end
      ST_INT: begin
        if (isReloadMode(ctrlMode)) begin
          irqFlag_d = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          ctrl_d[CTRL_ENABLE_BIT] = 1'b0;
          state_d                 = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ctrlWrite) begin
      ctrl_d    = TC_i_WData[3:0];
      irqFlag_d = 1'b0;
    end
    if (presetWrite) begin
      preset_d = TC_i_WData;
    end
  end

  // Single clocked process holding all timer state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      irqFlag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      irqFlag_q <= irqFlag_d;
    end
  end

  // Combinational read mux; unused CTRL bits and address 3 read as zero.
  always_comb begin
    TC_o_RData = 32'd0;
    case (TC_i_Addr)
      ADDR_CTRL:   TC_o_RData = {28'd0, ctrl_q};
      ADDR_PRESET: TC_o_RData = preset_q;
      ADDR_COUNT:  TC_o_RData = count_q;
      default:     TC_o_RData = 32'd0;
    endcase
  end

  assign TC_o_IRQ = irqFlag_q & ctrl_q[CTRL_IM_BIT];

endmodule
